// File: rtl/im_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Imported by the interface, the byte packer and the top level.
package im_loader_pkg;

    localparam int ADDR_W_DEF     = 16;
    localparam int WORD_W_DEF     = 32;
    localparam int BYTES_PER_WORD = 4;
    localparam int CNT_W          = $clog2(BYTES_PER_WORD);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/im_loader_if.sv
// Control, byte-stream and memory-write bundle of the loader.
// The DUT uses the slave view; the driving environment uses the master view.
interface im_loader_if
    import im_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int WORD_W = WORD_W_DEF
) ();

    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] word_count;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WORD_W-1:0] wr_data;
    logic              busy;
    logic              done;
    logic              wrap_err;
    logic [WORD_W-1:0] checksum;

    modport master (
        output start, base_addr, word_count, in_valid, in_data,
        input  in_ready, wr_en, wr_addr, wr_data, busy, done, wrap_err, checksum
    );

    modport slave (
        input  start, base_addr, word_count, in_valid, in_data,
        output in_ready, wr_en, wr_addr, wr_data, busy, done, wrap_err, checksum
    );

endinterface

// File: rtl/im_word_pack.sv
// Big-endian byte-to-word packer: counts accepted bytes and shifts them in.
// o_word is the word including the byte offered this cycle, valid with o_word_done.
module im_word_pack
    import im_loader_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_byte_en,
    input  logic [7:0]        i_byte,
    output logic [WORD_W-1:0] o_word,
    output logic              o_word_done
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BYTES_PER_WORD - 1);

    logic [CNT_W-1:0]  r_cnt;
    logic [WORD_W-9:0] r_shift;

    assign o_word      = {r_shift, i_byte};
    assign o_word_done = i_byte_en && (r_cnt == LAST_IDX);

    // Byte counter and shift register; the counter wraps naturally after the last byte.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (i_byte_en) begin
            r_cnt   <= r_cnt + CNT_W'(1'b1);
            r_shift <= o_word[WORD_W-9:0];
        end else begin
            r_cnt   <= r_cnt;
            r_shift <= r_shift;
        end
    end

endmodule

// File: rtl/im_loader.sv
// Loads a big-endian byte stream into instruction memory as whole words,
// tracking a running checksum and flagging address wrap-around.
module im_loader
    import im_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int WORD_W = WORD_W_DEF
) (
    input logic        clk,
    input logic        rst,
    im_loader_if.slave bus
);

    state_t            r_state;
    logic              r_in_ready;
    logic              r_wr_en;
    logic              r_busy;
    logic              r_done;
    logic              r_wrap_err;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_remaining;
    logic [WORD_W-1:0] r_wr_data;
    logic [WORD_W-1:0] r_checksum;

    logic              w_accept;
    logic              w_clr;
    logic              w_word_done;
    logic [WORD_W-1:0] w_word;

    // r_in_ready is high exactly while in RECV, so it doubles as the state qualifier.
    assign w_accept = bus.in_valid && r_in_ready;
    assign w_clr    = (r_state == ST_IDLE) && bus.start;

    im_word_pack #(.WORD_W(WORD_W)) u_pack (
        .clk         (clk),
        .rst         (rst),
        .i_clr       (w_clr),
        .i_byte_en   (w_accept),
        .i_byte      (bus.in_data),
        .o_word      (w_word),
        .o_word_done (w_word_done)
    );

    assign bus.in_ready = r_in_ready;
    assign bus.wr_en    = r_wr_en;
    assign bus.wr_addr  = r_wr_addr;
    assign bus.wr_data  = r_wr_data;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.wrap_err = r_wrap_err;
    assign bus.checksum = r_checksum;

    // Load sequencer; every output is set on entry to the state that owns it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b0;
            r_wr_en     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_wrap_err  <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_checksum  <= '0;
            r_addr      <= '0;
            r_remaining <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_addr      <= bus.base_addr;
                        r_remaining <= bus.word_count;
                        r_checksum  <= '0;
                        r_wrap_err  <= 1'b0;
                        r_busy      <= 1'b1;
                        if (bus.word_count != '0) begin
                            r_state    <= ST_RECV;
                            r_in_ready <= 1'b1;
                        end else begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RECV: begin
                    if (w_word_done) begin
                        r_state    <= ST_WRITE;
                        r_in_ready <= 1'b0;
                        r_wr_en    <= 1'b1;
                        r_wr_addr  <= r_addr;
                        r_wr_data  <= w_word;
                    end else begin
                        r_state <= ST_RECV;
                    end
                end
                ST_WRITE: begin
                    r_wr_en     <= 1'b0;
                    r_checksum  <= r_checksum + r_wr_data;
                    r_addr      <= r_addr + ADDR_W'(1'b1);
                    r_remaining <= r_remaining - ADDR_W'(1'b1);
                    if (r_remaining == ADDR_W'(1'b1)) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state    <= ST_RECV;
                        r_in_ready <= 1'b1;
                        // More words follow and the address is rolling over to zero.
                        if (r_addr == '1) begin
                            r_wrap_err <= 1'b1;
                        end else begin
                            r_wrap_err <= r_wrap_err;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_in_ready <= 1'b0;
                    r_wr_en    <= 1'b0;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_im_loader.sv
// Scoreboard bench for im_loader: expected writes are queued as loads are
// issued and retired by a monitor whenever the DUT strobes wr_en.
module tb_im_loader;
    import im_loader_pkg::*;

    localparam int AW = 16;
    localparam int WW = 32;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [WW-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    im_loader_if #(.ADDR_W(AW), .WORD_W(WW)) bus ();

    im_loader #(.ADDR_W(AW), .WORD_W(WW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    wr_t        exp_q[$];
    logic [7:0] bytes_q[$];
    int         n_checks  = 0;
    int         n_errors  = 0;
    int         wr_cnt    = 0;
    int         done_cnt  = 0;

    task automatic check_val(input string tag, input logic [47:0] act, input logic [47:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Monitor: retire expected writes and count done pulses.
    always @(negedge clk) begin
        wr_t e;
        if (bus.wr_en === 1'b1) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                check_val("unexpected_wr", 48'(bus.wr_addr), 48'hFFFF_FFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check_val("wr_addr", 48'(bus.wr_addr), 48'(e.addr));
                check_val("wr_data", 48'(bus.wr_data), 48'(e.data));
            end
        end
        if (bus.done === 1'b1) done_cnt++;
    end

    // Offer bytes_q one at a time; called just after a rising edge.
    task automatic send_bytes(input bit stall);
        int idx   = 0;
        int guard = 0;
        bit acc;
        bit tog   = 1'b1;
        while (idx < bytes_q.size() && guard < 200) begin
            bus.in_valid = stall ? tog : 1'b1;
            bus.in_data  = bytes_q[idx];
            tog = ~tog;
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk);
            #1;
            if (acc) idx++;
            guard++;
        end
        bus.in_valid = 1'b0;
        check_val("bytes_sent", 48'(idx), 48'(bytes_q.size()));
    endtask

    task automatic do_load(input logic [AW-1:0] base, input int count, input bit stall);
        logic [WW-1:0] w;
        logic [WW-1:0] sum  = '0;
        bit            wrap;
        int            d0   = done_cnt;
        int            w0   = wr_cnt;
        for (int i = 0; i < count; i++) begin
            w = {bytes_q[4*i], bytes_q[4*i+1], bytes_q[4*i+2], bytes_q[4*i+3]};
            exp_q.push_back('{addr: base + AW'(i), data: w});
            sum = sum + w;
        end
        wrap = (count >= 2) && ((int'(base) + count - 1) > 65535);
        bus.base_addr  = base;
        bus.word_count = AW'(count);
        bus.start      = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        send_bytes(stall);
        for (int k = 0; k < 40 && done_cnt == d0; k++) @(negedge clk);
        check_val("done_once", 48'(done_cnt - d0), 48'd1);
        check_val("wr_count", 48'(wr_cnt - w0), 48'(count));
        check_val("sb_empty", 48'(exp_q.size()), 48'd0);
        check_val("checksum", 48'(bus.checksum), 48'(sum));
        check_val("wrap_err", 48'(bus.wrap_err), 48'(wrap));
        @(negedge clk);
        check_val("busy_after", 48'(bus.busy), 48'd0);
        check_val("done_pulse", 48'(bus.done), 48'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        int d0;
        int w0;
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.base_addr  = '0;
        bus.word_count = '0;
        bus.in_valid   = 1'b0;
        bus.in_data    = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_in_ready", 48'(bus.in_ready), 48'd0);
        check_val("rst_wr_en", 48'(bus.wr_en), 48'd0);
        check_val("rst_busy", 48'(bus.busy), 48'd0);
        check_val("rst_done", 48'(bus.done), 48'd0);
        check_val("rst_wrap", 48'(bus.wrap_err), 48'd0);
        check_val("rst_wr_addr", 48'(bus.wr_addr), 48'd0);
        check_val("rst_wr_data", 48'(bus.wr_data), 48'd0);
        check_val("rst_checksum", 48'(bus.checksum), 48'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single word
        bytes_q = '{8'h12, 8'h34, 8'h56, 8'h78};
        do_load(16'h0010, 1, 1'b0);
        check_val("single_csum", 48'(bus.checksum), 48'h1234_5678);

        // Zero count: done two sample points after start is raised, no write
        d0 = done_cnt;
        w0 = wr_cnt;
        lat = 0;
        bus.word_count = 16'h0000;
        bus.base_addr  = 16'h0040;
        bus.start      = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            lat++;
            if (bus.done === 1'b1) break;
            @(posedge clk);
            #1;
            bus.start = 1'b0;
        end
        check_val("zero_latency", 48'(lat), 48'd2);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("zero_no_wr", 48'(wr_cnt - w0), 48'd0);
        check_val("zero_done", 48'(done_cnt - d0), 48'd1);

        // Stalled byte stream, two words
        bytes_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01, 8'h02, 8'h03, 8'h04};
        do_load(16'h0100, 2, 1'b1);

        // Address wrap
        bytes_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        do_load(16'hFFFF, 2, 1'b0);

        // Reset after two bytes, with start held to show reset wins
        d0 = done_cnt;
        w0 = wr_cnt;
        bus.base_addr  = 16'h0020;
        bus.word_count = 16'h0001;
        bus.start      = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bytes_q = '{8'hDE, 8'hAD};
        send_bytes(1'b0);
        rst       = 1'b1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check_val("midrst_busy", 48'(bus.busy), 48'd0);
        check_val("midrst_ready", 48'(bus.in_ready), 48'd0);
        repeat (6) @(posedge clk);
        #1;
        check_val("midrst_no_wr", 48'(wr_cnt - w0), 48'd0);
        check_val("midrst_no_done", 48'(done_cnt - d0), 48'd0);

        bytes_q = '{8'h12, 8'h34, 8'h56, 8'h78};
        do_load(16'h0010, 1, 1'b0);

        // Checksum overflow
        bytes_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h02};
        do_load(16'h0200, 2, 1'b0);
        check_val("ovf_csum", 48'(bus.checksum), 48'h0000_0001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
